// File: rtl/mips_lsu_pkg.sv
// Shared definitions for the MIPS load/store unit: op encodings, FSM states
// and small op-classification helpers.
package mips_lsu_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LBU = 3'd1,
    OP_LH  = 3'd2,
    OP_LHU = 3'd3,
    OP_LW  = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } lsu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  function automatic logic is_store(input logic [2:0] op);
    return op >= OP_SB;
  endfunction

  function automatic logic is_half(input logic [2:0] op);
    return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
  endfunction

  function automatic logic is_word(input logic [2:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mips_lsu_if.sv
// Data-memory port of the load/store unit.
// Handshake: the LSU raises mem_en and holds mem_addr/mem_wea/mem_wdata stable
// until the memory answers with a one-cycle mem_ack; mem_rdata is valid only
// in that ack cycle, and mem_ack while mem_en is low has no effect.
interface mips_lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int NB = DATA_W / 8;

  logic              mem_en;
  logic [NB-1:0]     mem_wea;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_en, mem_wea, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_en, mem_wea, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mips_lsu_lane_align.sv
// Byte-lane steering for sub-word accesses: alignment check, write-enable
// generation, store-data replication and little-endian load extraction.
module lsu_lane_align
  import mips_lsu_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int NB     = DATA_W / 8,
  localparam int LB     = $clog2(NB)
) (
  input  logic [2:0]        op,
  input  logic [LB-1:0]     lane,
  input  logic [31:0]       wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              misaligned,
  output logic [NB-1:0]     wea,
  output logic [DATA_W-1:0] wdata_rep,
  output logic [31:0]       load_data
);

  logic [31:0] shifted;

  always_comb begin
    misaligned = 1'b0;
    wea        = '0;
    wdata_rep  = {(NB/4){wdata}};
    load_data  = '0;
    shifted    = 32'(mem_rdata >> {lane, 3'b000});

    if (is_word(op)) begin
      misaligned = (lane[1:0] != 2'b00);
    end else if (is_half(op)) begin
      misaligned = lane[0];
    end

    // Data is replicated on every lane so the enables alone pick the bytes.
    if (is_word(op)) begin
      wdata_rep = {(NB/4){wdata}};
    end else if (is_half(op)) begin
      wdata_rep = {(NB/2){wdata[15:0]}};
    end else begin
      wdata_rep = {NB{wdata[7:0]}};
    end

    if (is_store(op)) begin
      if (is_word(op)) begin
        wea = NB'(4'hF) << lane;
      end else if (is_half(op)) begin
        wea = NB'(2'h3) << lane;
      end else begin
        wea = NB'(1'h1) << lane;
      end
    end

    case (op)
      OP_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
      OP_LBU:  load_data = {24'd0, shifted[7:0]};
      OP_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
      OP_LHU:  load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/mips_lsu.sv
// Load/store unit: accepts one core request at a time, runs it over the
// request/acknowledge memory port with a bounded wait, and reports faults.
module mips_lsu
  import mips_lsu_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              adel,
  output logic              ades,
  output logic              bus_err,
  output logic [ADDR_W-1:0] bad_addr,
  output lsu_state_e        dbg_state,
  mips_lsu_if.master        mem
);

  localparam int         NB        = DATA_W / 8;
  localparam int         LB        = $clog2(NB);
  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  lsu_state_e        state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NB-1:0]     wea_q, wea_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              adel_q, adel_d;
  logic              ades_q, ades_d;
  logic              berr_q, berr_d;
  logic [ADDR_W-1:0] bad_q, bad_d;

  logic              idle;
  logic [2:0]        sel_op;
  logic [LB-1:0]     sel_lane;
  logic              misaligned;
  logic [NB-1:0]     wea;
  logic [DATA_W-1:0] wdata_rep;
  logic [31:0]       load_data;

  // One lane aligner: it sees the live request in IDLE and the held request after.
  assign idle     = (state_q == ST_IDLE);
  assign sel_op   = idle ? req_op : op_q;
  assign sel_lane = idle ? req_addr[LB-1:0] : addr_q[LB-1:0];

  lsu_lane_align #(.DATA_W(DATA_W)) u_align (
    .op         (sel_op),
    .lane       (sel_lane),
    .wdata      (req_wdata),
    .mem_rdata  (mem.mem_rdata),
    .misaligned (misaligned),
    .wea        (wea),
    .wdata_rep  (wdata_rep),
    .load_data  (load_data)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wea_d    = wea_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    adel_d   = 1'b0;
    ades_d   = 1'b0;
    berr_d   = 1'b0;
    bad_d    = bad_q;
    stall    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (misaligned) begin
            adel_d = !is_store(req_op);
            ades_d = is_store(req_op);
            bad_d  = req_addr;
          end else begin
            stall   = 1'b1;
            op_d    = req_op;
            addr_d  = req_addr;
            wea_d   = wea;
            wdata_d = wdata_rep;
            cnt_d   = '0;
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        stall = 1'b1;
        cnt_d = cnt_q + 8'd1;
        if (mem.mem_ack) begin
          state_d = ST_RESP;
          cnt_d   = '0;
          if (!is_store(op_q)) begin
            rdata_d  = load_data;
            rvalid_d = 1'b1;
          end
        end else if (cnt_q == LAST_WAIT) begin
          state_d = ST_RESP;
          cnt_d   = '0;
          berr_d  = 1'b1;
          bad_d   = addr_q;
          if (!is_store(op_q)) begin
            rdata_d  = '0;
            rvalid_d = 1'b1;
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      addr_q   <= '0;
      wea_q    <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      adel_q   <= 1'b0;
      ades_q   <= 1'b0;
      berr_q   <= 1'b0;
      bad_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wea_q    <= wea_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      adel_q   <= adel_d;
      ades_q   <= ades_d;
      berr_q   <= berr_d;
      bad_q    <= bad_d;
    end
  end

  assign mem.mem_en    = (state_q == ST_ACCESS);
  assign mem.mem_wea   = (state_q == ST_ACCESS) ? wea_q : '0;
  assign mem.mem_addr  = {addr_q[ADDR_W-1:LB], {LB{1'b0}}};
  assign mem.mem_wdata = wdata_q;

  assign rdata       = rdata_q;
  assign rdata_valid = rvalid_q;
  assign adel        = adel_q;
  assign ades        = ades_q;
  assign bus_err     = berr_q;
  assign bad_addr    = bad_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mips_lsu.sv
// Directed bench for mips_lsu: a 32-bit instance with a latency-programmable
// memory responder and a 64-bit instance driven cycle by cycle.
module tb_mips_lsu;
  import mips_lsu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst32, rst64;
  always #5 clk = ~clk;

  // ---------------- DUT 32 ----------------
  logic        r32_valid;
  logic [2:0]  r32_op;
  logic [31:0] r32_addr, r32_wdata;
  logic        stall32, rv32, adel32, ades32, berr32;
  logic [31:0] rdata32, bad32;
  lsu_state_e  dbg32;
  mips_lsu_if #(.ADDR_W(32), .DATA_W(32)) m32();

  mips_lsu #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(15)) u_dut32 (
    .clk(clk), .rst(rst32), .req_valid(r32_valid), .req_op(r32_op),
    .req_addr(r32_addr), .req_wdata(r32_wdata), .stall(stall32),
    .rdata(rdata32), .rdata_valid(rv32), .adel(adel32), .ades(ades32),
    .bus_err(berr32), .bad_addr(bad32), .dbg_state(dbg32), .mem(m32)
  );

  // ---------------- DUT 64 ----------------
  logic        r64_valid;
  logic [2:0]  r64_op;
  logic [31:0] r64_addr, r64_wdata;
  logic        stall64, rv64, adel64, ades64, berr64;
  logic [31:0] rdata64, bad64;
  lsu_state_e  dbg64;
  mips_lsu_if #(.ADDR_W(32), .DATA_W(64)) m64();

  mips_lsu #(.ADDR_W(32), .DATA_W(64), .MAX_WAIT(4)) u_dut64 (
    .clk(clk), .rst(rst64), .req_valid(r64_valid), .req_op(r64_op),
    .req_addr(r64_addr), .req_wdata(r64_wdata), .stall(stall64),
    .rdata(rdata64), .rdata_valid(rv64), .adel(adel64), .ades(ades64),
    .bus_err(berr64), .bad_addr(bad64), .dbg_state(dbg64), .mem(m64)
  );

  // ---------------- scoreboard ----------------
  // Response word: {rdata_valid, adel, ades, bus_err, bad_addr[31:0], rdata[31:0]}
  logic [67:0] exp32_q[$];
  logic [67:0] exp64_q[$];
  // Memory word for DUT32: {wea[3:0], mem_addr[31:0], mem_wdata[31:0]}
  logic [67:0] mem_exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name, input string what);
    n_checks++;
    $display("FAIL %s: %s", name, what);
  endtask

  function automatic logic [67:0] resp(input logic rv, input logic ae, input logic as,
                                       input logic be, input logic [31:0] bad,
                                       input logic [31:0] rd);
    return {rv, ae, as, be, bad, rd};
  endfunction

  function automatic logic [67:0] mask_resp(input logic [67:0] act, input logic [67:0] exp);
    logic [67:0] m;
    m = act;
    if (exp[66:64] == 3'b000) m[63:32] = '0;
    if (!exp[67]) m[31:0] = '0;
    return m;
  endfunction

  always @(negedge clk) begin : monitor
    logic [67:0] e;
    if (rv32 || adel32 || ades32 || berr32) begin
      if (exp32_q.size() == 0) fail_now("resp32", "got an unexpected response, expected none");
      else begin
        e = exp32_q.pop_front();
        check("resp32", mask_resp({rv32, adel32, ades32, berr32, bad32, rdata32}, e), e);
      end
    end
    if (rv64 || adel64 || ades64 || berr64) begin
      if (exp64_q.size() == 0) fail_now("resp64", "got an unexpected response, expected none");
      else begin
        e = exp64_q.pop_front();
        check("resp64", mask_resp({rv64, adel64, ades64, berr64, bad64, rdata64}, e), e);
      end
    end
  end

  // ---------------- DUT32 memory responder ----------------
  int          ack_lat = 1;
  logic [31:0] rd_val  = '0;
  logic        stray_ack = 1'b0;
  int          en32_cycles = 0;

  initial begin : mem32
    logic [67:0] e;
    bit in_acc;
    int wcnt;
    in_acc = 0;
    wcnt = 0;
    m32.mem_ack   = 1'b0;
    m32.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (m32.mem_en === 1'b1) begin
        en32_cycles++;
        if (!in_acc) begin
          in_acc = 1;
          wcnt = 0;
          if (mem_exp_q.size() == 0) fail_now("mem32_access", "got an access, expected none");
          else begin
            e = mem_exp_q.pop_front();
            check("mem32_wea", m32.mem_wea, e[67:64]);
            check("mem32_addr", m32.mem_addr, e[63:32]);
            if (e[67:64] != 4'h0) check("mem32_wdata", m32.mem_wdata, e[31:0]);
          end
        end
        wcnt++;
        m32.mem_ack   = (wcnt == ack_lat);
        m32.mem_rdata = rd_val;
      end else begin
        in_acc = 0;
        m32.mem_ack = stray_ack;
      end
    end
  end

  // ---------------- DUT32 driver ----------------
  // Entered and left at a falling edge; the request is held while stall is high
  // and for the cycle in which stall drops.
  task automatic issue32(input string name, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input int lat, input logic [31:0] mrd,
                         input logic [3:0] exp_wea, input logic [31:0] exp_maddr,
                         input logic [31:0] exp_mwd, input logic [67:0] exp_resp,
                         input int exp_stall);
    int n;
    bit done;
    if (exp_resp[67:64] != 4'h0) exp32_q.push_back(exp_resp);
    if (exp_stall > 0) mem_exp_q.push_back({exp_wea, exp_maddr, exp_mwd});
    ack_lat   = lat;
    rd_val    = mrd;
    r32_valid = 1'b1;
    r32_op    = op;
    r32_addr  = addr;
    r32_wdata = wd;
    n = 0;
    done = 0;
    for (int i = 0; i < 64 && !done; i++) begin
      #1;
      if (stall32) n++;
      else done = 1;
      @(negedge clk);
    end
    if (!done) fail_now({name, "_stall"}, "stall never dropped within 64 cycles");
    else check({name, "_stall"}, n, exp_stall);
    r32_valid = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int en_before;
    rst32 = 1'b1; rst64 = 1'b1;
    r32_valid = 1'b0; r32_op = '0; r32_addr = '0; r32_wdata = '0;
    r64_valid = 1'b0; r64_op = '0; r64_addr = '0; r64_wdata = '0;
    m64.mem_ack = 1'b0; m64.mem_rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_stall32", stall32, 0);
    check("rst_rdata32", rdata32, 0);
    check("rst_flags32", {rv32, adel32, ades32, berr32}, 0);
    check("rst_bad32", bad32, 0);
    check("rst_mem32", {m32.mem_en, m32.mem_wea, m32.mem_addr}, 0);
    check("rst_state32", dbg32, ST_IDLE);
    check("rst_mem64", {m64.mem_en, m64.mem_wea, m64.mem_addr}, 0);
    check("rst_state64", dbg64, ST_IDLE);
    rst32 = 1'b0; rst64 = 1'b0;
    @(negedge clk);

    // name, op, addr, wdata, ack latency, mem_rdata, wea, mem_addr, mem_wdata, response, stall cycles
    issue32("sw_100", OP_SW, 32'h100, 32'hDEADBEEF, 2, 0, 4'hF, 32'h100, 32'hDEADBEEF, '0, 3);
    issue32("sb_103", OP_SB, 32'h103, 32'h000000A5, 1, 0, 4'h8, 32'h100, 32'hA5A5A5A5, '0, 2);
    issue32("lb_103", OP_LB, 32'h103, 0, 1, 32'hA5000000, 4'h0, 32'h100, 0,
            resp(1, 0, 0, 0, 0, 32'hFFFFFFA5), 2);
    issue32("lbu_103", OP_LBU, 32'h103, 0, 1, 32'hA5000000, 4'h0, 32'h100, 0,
            resp(1, 0, 0, 0, 0, 32'h000000A5), 2);
    issue32("lh_102", OP_LH, 32'h102, 0, 3, 32'h80010000, 4'h0, 32'h100, 0,
            resp(1, 0, 0, 0, 0, 32'hFFFF8001), 4);
    issue32("lhu_102", OP_LHU, 32'h102, 0, 1, 32'h80010000, 4'h0, 32'h100, 0,
            resp(1, 0, 0, 0, 0, 32'h00008001), 2);

    en_before = en32_cycles;
    issue32("lh_101", OP_LH, 32'h101, 0, 1, 0, 4'h0, 0, 0, resp(0, 1, 0, 0, 32'h101, 0), 0);
    issue32("sw_206", OP_SW, 32'h206, 32'h11223344, 1, 0, 4'h0, 0, 0, resp(0, 0, 1, 0, 32'h206, 0), 0);
    repeat (2) @(negedge clk);
    check("misaligned_no_mem_en", en32_cycles, en_before);

    issue32("lw_timeout", OP_LW, 32'h300, 0, 0, 32'hFFFFFFFF, 4'h0, 32'h300, 0,
            resp(1, 0, 0, 1, 32'h300, 32'h0), 16);

    // back-to-back accesses with no idle gap
    issue32("lw_104", OP_LW, 32'h104, 0, 1, 32'h12345678, 4'h0, 32'h104, 0,
            resp(1, 0, 0, 0, 0, 32'h12345678), 2);
    issue32("sw_108", OP_SW, 32'h108, 32'hCAFEF00D, 1, 0, 4'hF, 32'h108, 32'hCAFEF00D, '0, 2);
    issue32("lw_10c", OP_LW, 32'h10C, 0, 2, 32'h0BADF00D, 4'h0, 32'h10C, 0,
            resp(1, 0, 0, 0, 0, 32'h0BADF00D), 3);
    issue32("lb_101", OP_LB, 32'h101, 0, 1, 32'h00008000, 4'h0, 32'h100, 0,
            resp(1, 0, 0, 0, 0, 32'hFFFFFF80), 2);
    issue32("lhu_100", OP_LHU, 32'h100, 0, 1, 32'hFFFF1234, 4'h0, 32'h100, 0,
            resp(1, 0, 0, 0, 0, 32'h00001234), 2);
    issue32("sh_102", OP_SH, 32'h102, 32'h0000BEEF, 1, 0, 4'hC, 32'h100, 32'hBEEFBEEF, '0, 2);
    issue32("sb_101", OP_SB, 32'h101, 32'h1234567F, 1, 0, 4'h2, 32'h100, 32'h7F7F7F7F, '0, 2);
    @(negedge clk);
    check("rdata32_hold", rdata32, 32'h00001234);
    check("bad32_hold", bad32, 32'h300);

    // mem_ack outside ACCESS must be ignored
    en_before = en32_cycles;
    stray_ack = 1'b1;
    repeat (3) @(negedge clk);
    stray_ack = 1'b0;
    @(negedge clk);
    #1;
    check("stray_ack_state", dbg32, ST_IDLE);
    check("stray_ack_no_en", en32_cycles, en_before);

    // DUT64: SH at 0x10E lands in the top two lanes of the 0x108 word
    r64_valid = 1'b1; r64_op = OP_SH; r64_addr = 32'h10E; r64_wdata = 32'h00001234;
    #1 check("sh64_stall_req", stall64, 1);
    @(negedge clk); #1;
    check("sh64_en", m64.mem_en, 1);
    check("sh64_wea", m64.mem_wea, 8'hC0);
    check("sh64_addr", m64.mem_addr, 32'h108);
    check("sh64_wdata", m64.mem_wdata, 64'h1234123412341234);
    m64.mem_ack = 1'b1;
    @(negedge clk);
    m64.mem_ack = 1'b0;
    #1 check("sh64_stall_resp", stall64, 0);
    @(negedge clk);
    r64_valid = 1'b0;

    // DUT64: LW from the upper word of a doubleword
    exp64_q.push_back(resp(1, 0, 0, 0, 0, 32'hAABBCCDD));
    r64_valid = 1'b1; r64_op = OP_LW; r64_addr = 32'h10C; r64_wdata = '0;
    @(negedge clk); #1;
    check("lw64_wea", m64.mem_wea, 8'h00);
    check("lw64_addr", m64.mem_addr, 32'h108);
    m64.mem_rdata = 64'hAABBCCDD_00000000;
    m64.mem_ack   = 1'b1;
    @(negedge clk);
    m64.mem_ack = 1'b0;
    @(negedge clk);
    r64_valid = 1'b0;

    // DUT64: reset in the middle of an access aborts it silently
    r64_valid = 1'b1; r64_op = OP_LW; r64_addr = 32'h100;
    @(negedge clk); #1;
    check("abort_en_before", m64.mem_en, 1);
    rst64 = 1'b1;
    r64_valid = 1'b0;
    @(negedge clk); #1;
    check("abort_en_after", m64.mem_en, 0);
    check("abort_state", dbg64, ST_IDLE);
    rst64 = 1'b0;
    repeat (8) @(negedge clk);

    check("exp32_drained", exp32_q.size(), 0);
    check("exp64_drained", exp64_q.size(), 0);
    check("mem_exp_drained", mem_exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
